// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its neighbours.
package pipeline_pkg;
  localparam int REG_ADDR_WIDTH_DFLT = 5;
  localparam int CNT_WIDTH_DFLT      = 32;

  typedef enum logic {RUN, DISCARD} hazard_state_t;

  typedef struct packed {
    logic pc_en;
    logic pc_sel_redirect;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                         ex_mem_en: 1'b1, mem_wb_en: 1'b1, default: 1'b0};
  // Freeze: nothing advances, and WB sees a bubble while MEM is stuck.
  localparam pipe_ctrl_t CTRL_FREEZE = '{mem_wb_flush: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_RESET  = '{if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                         mem_wb_flush: 1'b1, default: 1'b0};
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-status inputs from the pipeline and the register controls driven back to it.
interface pipeline_hazard_if import pipeline_pkg::*; #(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT,
  parameter int CNT_WIDTH      = CNT_WIDTH_DFLT
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, icache_valid, dcache_busy;
  logic pc_en, pc_sel_redirect;
  logic if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush;
  logic [CNT_WIDTH-1:0] stall_cycles, redirect_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, icache_valid, dcache_busy,
    input  pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_wb_flush, stall_cycles, redirect_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, icache_valid, dcache_busy,
    output pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, mem_wb_flush, stall_cycles, redirect_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator; also shared with the forwarding unit.
module load_use_detect import pipeline_pkg::*; #(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  output logic                      lu
);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Priority stall/flush sequencer for the 5-stage pipeline with stall/redirect counters.
module pipeline_hazard_ctrl import pipeline_pkg::*; #(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT,
  parameter int CNT_WIDTH      = CNT_WIDTH_DFLT
) (
  input logic               clk,
  input logic               reset,
  pipeline_hazard_if.slave  bus
);
  hazard_state_t        state, state_nxt;
  pipe_ctrl_t           ctrl;
  logic                 lu, redir_take;
  logic [CNT_WIDTH-1:0] stall_q, redir_q;

  load_use_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_lu (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_uses_rs1 (bus.id_uses_rs1),
    .id_uses_rs2 (bus.id_uses_rs2),
    .ex_rd       (bus.ex_rd),
    .ex_mem_read (bus.ex_mem_read),
    .lu          (lu)
  );

  always_comb begin
    ctrl       = CTRL_RUN;
    state_nxt  = state;
    redir_take = 1'b0;
    if (reset) begin
      ctrl      = CTRL_RESET;
      state_nxt = RUN;
    end else if (bus.dcache_busy) begin
      // A pending redirect stays asserted by EX and is taken once MEM drains.
      ctrl = CTRL_FREEZE;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.ex_redirect) begin
            ctrl.pc_sel_redirect = 1'b1;
            ctrl.if_id_flush     = 1'b1;
            ctrl.id_ex_flush     = 1'b1;
            redir_take           = 1'b1;
            if (!bus.icache_valid) state_nxt = DISCARD;
          end else if (lu) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end else if (!bus.icache_valid) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_flush = 1'b1;
          end
        end
        DISCARD: begin
          // The in-flight fetch belongs to the old path; drop it when it lands.
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_flush = 1'b1;
          if (bus.icache_valid) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      state <= state_nxt;
      if (!ctrl.pc_en && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (redir_take  && (redir_q != '1)) redir_q <= redir_q + 1'b1;
    end
  end

  assign bus.pc_en           = ctrl.pc_en;
  assign bus.pc_sel_redirect = ctrl.pc_sel_redirect;
  assign bus.if_id_en        = ctrl.if_id_en;
  assign bus.if_id_flush     = ctrl.if_id_flush;
  assign bus.id_ex_en        = ctrl.id_ex_en;
  assign bus.id_ex_flush     = ctrl.id_ex_flush;
  assign bus.ex_mem_en       = ctrl.ex_mem_en;
  assign bus.mem_wb_en       = ctrl.mem_wb_en;
  assign bus.mem_wb_flush    = ctrl.mem_wb_flush;
  assign bus.stall_cycles    = stall_q;
  assign bus.redirect_count  = redir_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + random checks of pipeline_hazard_ctrl against a table-driven reference model.
module tb_pipeline_hazard_ctrl;
  localparam int RW   = 5;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_if #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) bus ();
  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Reference model state: are we dropping a stale fetch, plus the two counters.
  bit m_disc;
  int m_stall, m_redir;
  int checks, passes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Bit order: pc_en pc_sel if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en mem_wb_en mem_wb_flush
  function automatic logic [8:0] expect_ctrl();
    logic lu;
    lu = bus.ex_mem_read && bus.ex_rd != 0 &&
         ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    if (reset)             return 9'b0_0_0_1_0_1_0_0_1;
    if (bus.dcache_busy)   return 9'b0_0_0_0_0_0_0_0_1;
    if (m_disc)            return 9'b0_0_1_1_1_0_1_1_0;
    if (bus.ex_redirect)   return 9'b1_1_1_1_1_1_1_1_0;
    if (lu)                return 9'b0_0_0_0_1_1_1_1_0;
    if (!bus.icache_valid) return 9'b0_0_1_1_1_0_1_1_0;
    return 9'b1_0_1_0_1_0_1_1_0;
  endfunction

  // Called just after a negedge with inputs already applied; returns at the next negedge.
  task automatic step(input string tag);
    logic [8:0] exp, got;
    bit taken;
    #1;
    exp = expect_ctrl();
    got = {bus.pc_en, bus.pc_sel_redirect, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
           bus.id_ex_flush, bus.ex_mem_en, bus.mem_wb_en, bus.mem_wb_flush};
    check({tag, "_ctrl"},  32'(got), 32'(exp));
    check({tag, "_stall"}, 32'(bus.stall_cycles), 32'(m_stall));
    check({tag, "_redir"}, 32'(bus.redirect_count), 32'(m_redir));
    @(posedge clk);
    if (reset) begin
      m_disc = 0; m_stall = 0; m_redir = 0;
    end else begin
      taken = !bus.dcache_busy && !m_disc && bus.ex_redirect;
      if (!exp[8] && m_stall < CMAX) m_stall++;
      if (taken && m_redir < CMAX) m_redir++;
      if (!bus.dcache_busy) m_disc = m_disc ? !bus.icache_valid : (taken && !bus.icache_valid);
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.ex_rd = '0; bus.ex_mem_read = 0; bus.ex_redirect = 0;
    bus.icache_valid = 1; bus.dcache_busy = 0;
  endtask

  task automatic do_reset();
    reset = 1; step("rst"); reset = 0;
  endtask

  initial begin
    checks = 0; passes = 0; m_disc = 0; m_stall = 0; m_redir = 0;
    set_idle();
    reset = 1;
    @(posedge clk); @(negedge clk);
    step("reset");
    reset = 0;
    step("first_run");

    // Load-use on rs2: one bubble, then the load has moved on.
    bus.ex_mem_read = 1; bus.ex_rd = 5; bus.id_rs2 = 5; bus.id_uses_rs2 = 1;
    step("lu");
    set_idle();
    step("lu_after");
    check("lu_stall_cnt", 32'(bus.stall_cycles), 32'd1);
    bus.ex_mem_read = 1; bus.ex_rd = 0; bus.id_rs2 = 0; bus.id_uses_rs2 = 1;
    step("lu_x0");
    bus.ex_rd = 9; bus.id_rs1 = 9; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    step("lu_unused_rs1");
    bus.id_uses_rs1 = 1;
    step("lu_rs1");
    set_idle();
    step("idle1");
    check("lu_x0_stall_cnt", 32'(bus.stall_cycles), 32'd2);

    // Redirect with fetch data ready: stays in RUN.
    bus.ex_redirect = 1;
    step("redir_ready");
    set_idle();
    step("redir_ready_after");
    check("redir_cnt1", 32'(bus.redirect_count), 32'd1);

    // Redirect with a fetch outstanding, concurrent load-use ignored.
    bus.ex_redirect = 1; bus.icache_valid = 0;
    bus.ex_mem_read = 1; bus.ex_rd = 3; bus.id_rs1 = 3; bus.id_uses_rs1 = 1;
    step("redir_pend");
    set_idle(); bus.icache_valid = 0;
    for (int i = 0; i < 3; i++) step("discard");
    bus.icache_valid = 1;
    step("discard_last");
    step("run_again");
    check("pend_redir_cnt", 32'(bus.redirect_count), 32'd2);

    // Freeze over a pending redirect.
    do_reset();
    bus.dcache_busy = 1; bus.ex_redirect = 1;
    for (int i = 0; i < 4; i++) step("freeze");
    bus.dcache_busy = 0;
    step("freeze_redir");
    set_idle();
    step("freeze_after");
    check("freeze_stall_cnt", 32'(bus.stall_cycles), 32'd4);
    check("freeze_redir_cnt", 32'(bus.redirect_count), 32'd1);

    // Reset in DISCARD: back in RUN, proven by a load-use stall instead of a discard flush.
    bus.ex_redirect = 1; bus.icache_valid = 0;
    step("rd_redir");
    bus.ex_redirect = 0;
    step("rd_discard");
    reset = 1;
    step("rd_reset");
    reset = 0;
    bus.ex_mem_read = 1; bus.ex_rd = 7; bus.id_rs2 = 7; bus.id_uses_rs2 = 1;
    step("rd_run_lu");
    check("rd_if_id_flush", 32'(bus.if_id_flush), 32'd0);
    set_idle();

    // Saturation of both counters.
    do_reset();
    bus.icache_valid = 0;
    for (int i = 0; i < CMAX + 4; i++) step("sat_stall");
    check("sat_stall_cnt", 32'(bus.stall_cycles), 32'(CMAX));
    bus.icache_valid = 1; bus.ex_redirect = 1;
    for (int i = 0; i < CMAX + 4; i++) step("sat_redir");
    check("sat_redir_cnt", 32'(bus.redirect_count), 32'(CMAX));
    set_idle();

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset            = ($urandom_range(0, 299) == 0);
      bus.dcache_busy  = ($urandom_range(0, 4) == 0);
      bus.ex_redirect  = ($urandom_range(0, 6) == 0);
      bus.icache_valid = ($urandom_range(0, 9) < 7);
      bus.ex_mem_read  = $urandom_range(0, 1);
      bus.ex_rd        = RW'($urandom_range(0, 3));
      bus.id_rs1       = RW'($urandom_range(0, 3));
      bus.id_rs2       = RW'($urandom_range(0, 3));
      bus.id_uses_rs1  = $urandom_range(0, 1);
      bus.id_uses_rs2  = $urandom_range(0, 1);
      step("rand");
    end
    reset = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Each cycle it drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves data-cache stalls, EX-stage redirects, load-use hazards and instruction-fetch bubbles in a fixed priority order. A small FSM discards stale fetches after a redirect, and two saturating performance counters track stall cycles and redirects.

## Interface
- REG_ADDR_WIDTH, 5, architectural register index width
- CNT_WIDTH, 32, width of each performance counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  REG_ADDR_WIDTH each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source
- ex_rd  in  REG_ADDR_WIDTH  destination of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- ex_redirect  in  1  level; EX branch/jump resolved to a non-sequential PC
- icache_valid  in  1  fetch data is valid this cycle
- dcache_busy  in  1  MEM stage cannot complete this cycle
- pc_en, pc_sel_redirect  out  1 each  PC load enable; select the redirect target
- if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush  out  1 each  pipeline register controls; a flush loads all-zero (bubble) and overrides enable
- stall_cycles, redirect_count  out  CNT_WIDTH each  performance counters

## Operation
- FSM states: RUN, DISCARD.
- Load-use hazard (lu): ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
- RUN decodes in priority order; the first matching case wins:
  1. dcache_busy: all *_en = 0 and mem_wb_flush = 1. Any redirect is ignored; it stays asserted because EX holds its instruction.
  2. ex_redirect: pc_en = 1, pc_sel_redirect = 1, if_id_flush = 1, id_ex_flush = 1; all other enables = 1. Go to DISCARD if icache_valid = 0, otherwise stay in RUN. redirect_count += 1.
  3. lu: pc_en = 0, if_id_en = 0, id_ex_flush = 1, ex_mem_en = 1, mem_wb_en = 1.
  4. !icache_valid: pc_en = 0, if_id_flush = 1; all downstream enables = 1.
  5. Otherwise: all enables = 1, no flush.
- DISCARD:
  - dcache_busy behaves as in RUN case 1.
  - Otherwise pc_en = 0 and if_id_flush = 1; ID/EX, EX/MEM and MEM/WB run normally, with no lu check because ID holds a bubble.
  - The cycle icache_valid = 1 the stale word is dropped; the next state is RUN.
  - A new ex_redirect in DISCARD cannot occur (EX holds a bubble) and is ignored.
- Unlisted outputs default to en = 1 and flush = 0, except in case 1 where all en = 0.
- stall_cycles increments every non-reset cycle with pc_en = 0.
- Both counters saturate at all-ones and do not wrap.
- Load-use decode and all output decode are combinational from the inputs and the current state.

## Timing
- Reset (while reset = 1): state = RUN, counters = 0, all *_en = 0, if_id_flush = id_ex_flush = mem_wb_flush = 1, pc_sel_redirect = 0. All enables = 1 in the first cycle after reset deasserts, given no hazards.
- Control outputs have 0 cycles of latency relative to their inputs. The FSM and counters update at the next edge.
- A load-use hazard costs exactly 1 bubble. Next cycle the load is in MEM, so lu clears.
- A redirect costs 2 bubbles, plus the DISCARD duration when a fetch is outstanding.
- Simultaneous dcache_busy and redirect: freeze first; the redirect is taken on the first cycle dcache_busy = 0.
- Simultaneous redirect and lu: the redirect wins; the ID instruction is flushed, so no load-use bubble is inserted.
- Reset asserted in DISCARD: return to RUN immediately and do not wait for icache_valid.

## Structure
- pipeline_pkg holds:
  - hazard_state_t enum {RUN, DISCARD}
  - REG_ADDR_WIDTH default constant
  - a pipe_ctrl_t struct bundling the seven register controls plus pc_en and pc_sel_redirect
- Sub-module load_use_detect: purely combinational comparator producing lu. It is reused by the forwarding unit.
- Counters live inline in pipeline_hazard_ctrl.

## Test plan
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1, icache_valid = 1 -> exactly one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1; stall_cycles = 1. Repeat with ex_rd = 0 -> no stall.
- Redirect with fetch ready: ex_redirect = 1, icache_valid = 1 -> one cycle of pc_sel_redirect = 1, if_id_flush = id_ex_flush = 1; state stays RUN; redirect_count = 1.
- Redirect with fetch outstanding: ex_redirect = 1, icache_valid = 0, then icache_valid held 0 for 3 cycles then 1 -> DISCARD for 4 cycles, with if_id_flush = 1 each cycle; RUN on the 5th.
- Freeze over redirect: dcache_busy = 1 for 4 cycles with ex_redirect = 1 -> all en = 0 and mem_wb_flush = 1 for 4 cycles, no redirect; redirect taken in cycle 5; stall_cycles = 4.
- Reset mid-DISCARD: assert reset for 1 cycle -> outputs at reset values, counters = 0, RUN afterwards.
- Saturation: force stall_cycles to all-ones minus 1 and stall 3 cycles -> counter holds all-ones.
